mul_arbiter: RTL and testbench

- Shares one iterative 32x32->64 multiplier (valid_in/valid_out pulse protocol, variable latency) between N_REQ requesters.
- Round-robin arbitration. Operands are latched, one multiply is issued, completion is awaited, and the product is routed back to the granted requester.
- Sits between the functional-unit clients and the single multiplier instance. The multiplier is external; its handshake signals are exposed on the mul_* ports.

---
 rtl/mul_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mul_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one iterative WIDTHxWIDTH->2*WIDTH
// multiplier between N_REQ requesters. A request is granted in IDLE, its
// operands are latched, one multiply is issued, and the product is routed back
// to the granted requester. Only one request is in flight at a time.
//
// Optional feature: define MUL_TIMEOUT_EN to enable a WAIT watchdog. A WAIT
// that lasts TIMEOUT_CYCLES cycles with no mul_valid_out completes with
// resp_r=0 and resp_err=1.
//
// Ports:
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   req_valid      per-requester request, held until accepted
//   req_a, req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot accept pulse (IDLE only)
//   resp_valid     one-hot result pulse
//   resp_r         product, held until the next result
//   resp_err       timeout flag alongside resp_valid (0 without MUL_TIMEOUT_EN)
//   busy           high whenever the arbiter is not in IDLE
//   mul_valid_in   one-cycle start pulse to the multiplier
//   mul_a, mul_b   latched operands to the multiplier
//   mul_r          multiplier product
//   mul_valid_out  multiplier done pulse
module mul_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]       resp_r,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     mul_valid_in,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_r,
    input  logic                     mul_valid_out
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mul_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] resp_r_q, resp_r_d;

    // Unpacked views of the packed operand buses, indexed by grant.
    logic [WIDTH-1:0] req_a_arr [N_REQ];
    logic [WIDTH-1:0] req_b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign req_b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: first set req_valid bit at rr_ptr, rr_ptr+1, ... mod N_REQ.
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    int unsigned      scan_idx;
    logic [PTR_W-1:0] scan_ptr;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        scan_ptr  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % N_REQ;
            scan_ptr = PTR_W'(scan_idx);
            if (!win_found && req_valid[scan_ptr]) begin
                win_found = 1'b1;
                win_idx   = scan_ptr;
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        resp_r_d     = resp_r_q;
        req_ready    = '0;
        resp_valid   = '0;
        mul_valid_in = 1'b0;
`ifdef MUL_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    // Gated by rst_n so no accept leaks out while reset is held.
                    req_ready[win_idx] = rst_n;
                    grant_d            = win_idx;
                    mul_a_d            = req_a_arr[win_idx];
                    mul_b_d            = req_b_arr[win_idx];
                    state_d            = StIssue;
                end
            end

            StIssue: begin
                // mul_valid_out is deliberately not looked at here.
                mul_valid_in = 1'b1;
                state_d      = StWait;
`ifdef MUL_TIMEOUT_EN
                to_cnt_d     = '0;
`endif
            end

            StWait: begin
                if (mul_valid_out) begin
                    resp_r_d = mul_r;
                    state_d  = StResp;
`ifdef MUL_TIMEOUT_EN
                    err_d    = 1'b0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // TIMEOUT_CYCLES WAIT cycles elapsed without completion.
                    resp_r_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end

            StResp: begin
                resp_valid[grant_q] = 1'b1;
                rr_ptr_d = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            resp_r_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            resp_r_q <= resp_r_d;
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign resp_err = (state_q == StResp) && err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign busy   = (state_q != StIdle);
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign resp_r = resp_r_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: transaction-level reference model,
// an external multiplier model with random latency, directed scenarios with
// literal expectations, and a randomized traffic phase.
module tb_mul_arbiter;

    localparam int N = 4;
    localparam int W = 32;
`ifdef MUL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 128;
`endif

    typedef logic [63:0] q64_t[$];

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, resp_valid;
    logic [2*W-1:0] resp_r;
    logic           resp_err, busy, mul_valid_in;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_r;
    logic           mul_valid_out;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*W +: W] = op_a[g];
        assign req_b[g*W +: W] = op_b[g];
    end

    mul_arbiter #(
        .N_REQ(N),
        .WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_r(resp_r),
        .resp_err(resp_err),
        .busy(busy),
        .mul_valid_in(mul_valid_in),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_r(mul_r),
        .mul_valid_out(mul_valid_out)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] at(q64_t q, int i);
        return (i < q.size()) ? q[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic int pick(logic [N-1:0] v, int rr);
        for (int k = 0; k < N; k++) begin
            int idx = (rr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: one transaction at a time, described by age since accept.
    bit          m_inflight, m_resp_now, m_err_now;
    int          m_age, m_grant, m_rr;
    logic [W-1:0] m_a, m_b;
    logic [63:0] m_exp_r;

    // External multiplier model and stimulus controls.
    bit          mul_pend, silent, rnd, renew;
    int          mul_cnt, lat_lo, lat_hi;
    logic [63:0] mul_prod;
    logic [N-1:0] acc_mask;

    q64_t grant_log, rdy_log, r_log, rv_log, err_log, ia_log, ib_log;

    int w_idx;
    logic [N-1:0] e_ready, e_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_r", resp_r, 64'd0);
            chk("rst_resp_err", 64'(resp_err), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
            chk("rst_mul_a", 64'(mul_a), 64'd0);
            chk("rst_mul_b", 64'(mul_b), 64'd0);
            m_inflight = 0; m_resp_now = 0; m_err_now = 0;
            m_rr = 0; m_age = 0; m_exp_r = '0;
            acc_mask = '0;
        end else begin
            w_idx   = m_inflight ? -1 : pick(req_valid, m_rr);
            e_ready = (w_idx >= 0) ? N'(1 << w_idx) : '0;
            e_rv    = m_resp_now ? N'(1 << m_grant) : '0;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("busy", 64'(busy), 64'(m_inflight));
            chk("mul_valid_in", 64'(mul_valid_in), 64'(m_inflight && m_age == 1));
            chk("resp_r", resp_r, m_exp_r);
            chk("resp_err", 64'(resp_err), 64'(m_resp_now && m_err_now));
            if (m_inflight) begin
                chk("mul_a", 64'(mul_a), 64'(m_a));
                chk("mul_b", 64'(mul_b), 64'(m_b));
            end

            if (req_ready != 0) begin
                rdy_log.push_back(64'(req_ready));
                grant_log.push_back(64'(w_idx));
            end
            if (resp_valid != 0) begin
                rv_log.push_back(64'(resp_valid));
                r_log.push_back(resp_r);
                err_log.push_back(64'(resp_err));
            end
            if (mul_valid_in) begin
                ia_log.push_back(64'(mul_a));
                ib_log.push_back(64'(mul_b));
                if (!silent) begin
                    mul_pend = 1;
                    mul_cnt  = $urandom_range(lat_hi, lat_lo);
                    mul_prod = {32'b0, mul_a} * {32'b0, mul_b};
                end
            end
            acc_mask = req_ready;

            if (!m_inflight) begin
                if (w_idx >= 0) begin
                    m_inflight = 1; m_age = 1; m_grant = w_idx;
                    m_a = op_a[w_idx]; m_b = op_b[w_idx];
                    m_resp_now = 0; m_err_now = 0;
                end
            end else if (m_resp_now) begin
                m_inflight = 0;
                m_resp_now = 0;
                m_rr = (m_grant + 1) % N;
            end else begin
                if (m_age >= 2 && mul_valid_out) begin
                    m_resp_now = 1; m_err_now = 0;
                    m_exp_r = {32'b0, m_a} * {32'b0, m_b};
                end
`ifdef MUL_TIMEOUT_EN
                else if (m_age >= 2 && m_age - 1 >= TO) begin
                    m_resp_now = 1; m_err_now = 1; m_exp_r = '0;
                end
`endif
                m_age++;
            end
        end
    end

    function automatic logic [W-1:0] rand_op();
        int s = $urandom_range(7);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    // Driver at posedge+1: multiplier responses and requester follow-up.
    always @(posedge clk) begin
        #1;
        mul_valid_out = 1'b0;
        mul_r = {$urandom, $urandom};
        if (mul_pend) begin
            mul_cnt--;
            if (mul_cnt <= 0) begin
                mul_valid_out = 1'b1;
                mul_r = mul_prod;
                mul_pend = 0;
            end
        end else if (rnd && (!m_inflight || m_age == 1) && $urandom_range(7) == 0) begin
            // Spurious done pulse where the arbiter must ignore it.
            mul_valid_out = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (rnd) begin
                if (acc_mask[i]) begin
                    req_valid[i] = $urandom_range(1) == 1;
                    op_a[i] = rand_op(); op_b[i] = rand_op();
                end else if (!req_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req_valid[i] = 1'b1;
                        op_a[i] = rand_op(); op_b[i] = rand_op();
                    end
                end else if ($urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end else if (acc_mask[i] && !renew) begin
                req_valid[i] = 1'b0;
            end
        end
        acc_mask = '0;
    end

    task automatic clear_logs();
        grant_log.delete(); rdy_log.delete(); r_log.delete(); rv_log.delete();
        err_log.delete(); ia_log.delete(); ib_log.delete();
    endtask

    task automatic wait_resps(int n, int budget, string name);
        int c = 0;
        while (r_log.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk(name, 64'(r_log.size() >= n), 64'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mul_valid_out = 1'b0;
        mul_r = '0;
        mul_pend = 0; silent = 0; rnd = 0; renew = 1;
        lat_lo = 1; lat_hi = 4;
        acc_mask = '0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(i + 1);
            op_b[i] = W'(i + 10);
        end

        // Reset held with all requests high; then fairness from requester 0.
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_logs();
        begin
            int c = 0;
            while (grant_log.size() < 5 && c < 200) begin
                @(posedge clk);
                c++;
            end
        end
        #2;
        renew = 0;
        req_valid = '0;
        wait_resps(5, 200, "fair_done");
        chk("fair_g0", at(grant_log, 0), 64'd0);
        chk("fair_g1", at(grant_log, 1), 64'd1);
        chk("fair_g2", at(grant_log, 2), 64'd2);
        chk("fair_g3", at(grant_log, 3), 64'd3);
        chk("fair_g4", at(grant_log, 4), 64'd0);
        chk("fair_r0", at(r_log, 0), 64'd10);
        chk("fair_r1", at(r_log, 1), 64'd22);
        chk("fair_r2", at(r_log, 2), 64'd36);
        chk("fair_r3", at(r_log, 3), 64'd52);

        // Single request from requester 2.
        repeat (2) @(posedge clk);
        #2;
        clear_logs();
        op_a[2] = 7; op_b[2] = 9;
        req_valid = 4'b0100;
        wait_resps(1, 100, "single_done");
        chk("single_ready", at(rdy_log, 0), 64'h4);
        chk("single_mul_a", at(ia_log, 0), 64'd7);
        chk("single_mul_b", at(ib_log, 0), 64'd9);
        chk("single_issues", 64'(ia_log.size()), 64'd1);
        chk("single_rv", at(rv_log, 0), 64'h4);
        chk("single_r", at(r_log, 0), 64'd63);

        // Wrap with all-ones operands, then scan restarts at 0.
        clear_logs();
        op_a[3] = '1; op_b[3] = '1;
        req_valid = 4'b1000;
        wait_resps(1, 100, "wrap_done");
        chk("wrap_r", at(r_log, 0), 64'hFFFF_FFFE_0000_0001);
        clear_logs();
        op_a[0] = 3; op_b[0] = 4; op_a[3] = 5; op_b[3] = 6;
        req_valid = 4'b1001;
        wait_resps(2, 100, "wrap2_done");
        chk("wrap_next_g0", at(grant_log, 0), 64'd0);
        chk("wrap_next_g1", at(grant_log, 1), 64'd3);
        chk("wrap_next_r0", at(r_log, 0), 64'd12);
        chk("wrap_next_r1", at(r_log, 1), 64'd30);

        // Reset during WAIT: no response, stale done ignored afterwards.
        clear_logs();
        lat_lo = 20; lat_hi = 20;
        op_a[1] = 11; op_b[1] = 12;
        req_valid = 4'b0010;
        begin
            int c = 0;
            while (ia_log.size() < 1 && c < 50) begin
                @(posedge clk);
                c++;
            end
        end
        chk("midrst_issued", 64'(ia_log.size()), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        lat_lo = 1; lat_hi = 4;
        repeat (30) @(posedge clk);
        #2;
        chk("midrst_no_resp", 64'(rv_log.size()), 64'd0);
        chk("midrst_stale_fired", 64'(mul_pend), 64'd0);
        op_a[1] = 5; op_b[1] = 6;
        req_valid = 4'b0010;
        wait_resps(1, 100, "midrst_done");
        chk("midrst_rv", at(rv_log, 0), 64'h2);
        chk("midrst_r", at(r_log, 0), 64'd30);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 6;
        rnd = 1;
        repeat (2500) @(posedge clk);
        #2;
        rnd = 0;
        req_valid = '0;
        begin
            int c = 0;
            while ((m_inflight || mul_pend) && c < 200) begin
                @(posedge clk);
                c++;
            end
            chk("rand_drain", 64'(m_inflight), 64'd0);
        end

`ifdef MUL_TIMEOUT_EN
        // Multiplier never answers: watchdog completes with an error.
        repeat (2) @(posedge clk);
        #2;
        clear_logs();
        silent = 1;
        op_a[0] = 3; op_b[0] = 3;
        req_valid = 4'b0001;
        wait_resps(1, 100, "timeout_done");
        chk("timeout_rv", at(rv_log, 0), 64'h1);
        chk("timeout_err", at(err_log, 0), 64'd1);
        chk("timeout_r", at(r_log, 0), 64'd0);
        chk("timeout_idle", 64'(busy), 64'd0);
        silent = 0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
